// File: rtl/emu_pkg.sv
// emu_pkg: shared types and constants for the challenge/response emulation core.
// Holds the FSM state type, the challenge LFSR width, its tap positions and the
// feedback helper used by lfsr56.
package emu_pkg;

    localparam int LFSR_W = 56;
    localparam int TAP0   = 55;
    localparam int TAP1   = 54;
    localparam int TAP2   = 34;
    localparam int TAP3   = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_EVAL,
        ST_GAP,
        ST_DONE
    } state_t;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return v[TAP0] ^ v[TAP1] ^ v[TAP2] ^ v[TAP3];
    endfunction

endpackage

// File: rtl/lfsr56.sv
// lfsr56: combinational one-step advance of the 56-bit challenge register.
// Ports:
//   chl_i  current challenge
//   chl_o  challenge after one LFSR step (zero is passed through unchanged)
module lfsr56
    import emu_pkg::*;
(
    input  logic [LFSR_W-1:0] chl_i,
    output logic [LFSR_W-1:0] chl_o
);

    // Zero is the lock-up state of this LFSR, so it is never stepped.
    assign chl_o = (chl_i == '0) ? chl_i : {chl_i[LFSR_W-2:0], lfsr_fb(chl_i)};

endmodule

// File: rtl/emu_core.sv
// emu_core: emulated challenge/response evaluator with guard, repeat and run control.
// Ports:
//   clk, rst_n       core clock, synchronous active-low reset
//   i_go / o_done    4-phase run handshake with the evaluation controller
//   i_chl_seed       initial challenge, loaded when a run is accepted
//   i_key1           emulation key, must be stable while a run is active
//   i_chx            challenges per run (0 behaves as 1)
//   i_grd            guard cycles before each challenge (0 = no guard)
//   i_rpt            evaluations per challenge (0 behaves as 1)
//   o_state1         current challenge register
//   o_q              registered response bit, updated on each evaluation
//   o_valid          one-cycle pulse per evaluation
//   o_done           run complete, held until i_go drops
module emu_core
    import emu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_go,
    input  logic [LFSR_W-1:0] i_chl_seed,
    input  logic [LFSR_W-1:0] i_key1,
    input  logic [7:0]        i_chx,
    input  logic [7:0]        i_grd,
    input  logic [3:0]        i_rpt,
    output logic [LFSR_W-1:0] o_state1,
    output logic              o_q,
    output logic              o_valid,
    output logic              o_done
);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   chl_q, chl_d, chl_step;
    logic                q_q, q_d;
    logic [3:0]          rpt_q, rpt_d, rpt_inc, eff_rpt;
    logic [7:0]          chx_q, chx_d, chx_inc, eff_chx;
    logic [7:0]          grd_q, grd_d;
    state_t              enter_st;

    lfsr56 u_lfsr (
        .chl_i (chl_q),
        .chl_o (chl_step)
    );

    assign eff_rpt  = (i_rpt == '0) ? 4'd1 : i_rpt;
    assign eff_chx  = (i_chx == '0) ? 8'd1 : i_chx;
    // rpt_q < eff_rpt <= 15 and chx_q < eff_chx <= 255, so neither increment wraps.
    assign rpt_inc  = rpt_q + 4'd1;
    assign chx_inc  = chx_q + 8'd1;
    // A zero guard skips GUARD entirely and goes straight to the evaluation.
    assign enter_st = (i_grd == '0) ? ST_EVAL : ST_GUARD;

    always_comb begin
        state_d = state_q;
        chl_d   = chl_q;
        rpt_d   = rpt_q;
        chx_d   = chx_q;
        grd_d   = grd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    chl_d   = (i_chl_seed == '0) ? LFSR_W'(1) : i_chl_seed;
                    rpt_d   = '0;
                    chx_d   = '0;
                    grd_d   = i_grd;
                    state_d = enter_st;
                end
            end
            ST_GUARD: begin
                if (!i_go) begin
                    state_d = ST_IDLE;
                end else if (grd_q <= 8'd1) begin
                    state_d = ST_EVAL;
                end else begin
                    grd_d = grd_q - 8'd1;
                end
            end
            ST_EVAL: state_d = i_go ? ST_GAP : ST_IDLE;
            ST_GAP: begin
                if (!i_go) begin
                    state_d = ST_IDLE;
                end else if (rpt_inc < eff_rpt) begin
                    rpt_d   = rpt_inc;
                    state_d = ST_EVAL;
                end else begin
                    chl_d   = chl_step;
                    rpt_d   = '0;
                    chx_d   = chx_inc;
                    grd_d   = i_grd;
                    state_d = (chx_inc == eff_chx) ? ST_DONE : enter_st;
                end
            end
            ST_DONE: state_d = i_go ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // The response is captured on entry to EVAL so it appears together with o_valid.
        q_d = (state_d == ST_EVAL) ? ^(chl_d & i_key1) : q_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            chl_q   <= '0;
            q_q     <= 1'b0;
            rpt_q   <= '0;
            chx_q   <= '0;
            grd_q   <= '0;
        end else begin
            state_q <= state_d;
            chl_q   <= chl_d;
            q_q     <= q_d;
            rpt_q   <= rpt_d;
            chx_q   <= chx_d;
            grd_q   <= grd_d;
        end
    end

    assign o_state1 = chl_q;
    assign o_q      = q_q;
    assign o_valid  = (state_q == ST_EVAL);
    assign o_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_emu_core.sv
// tb_emu_core: randomized self-checking bench for emu_core against a run-level reference model.
module tb_emu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_go;
    logic [55:0] i_chl_seed;
    logic [55:0] i_key1;
    logic [7:0]  i_chx;
    logic [7:0]  i_grd;
    logic [3:0]  i_rpt;
    logic [55:0] o_state1;
    logic        o_q;
    logic        o_valid;
    logic        o_done;

    emu_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_go       (i_go),
        .i_chl_seed (i_chl_seed),
        .i_key1     (i_key1),
        .i_chx      (i_chx),
        .i_grd      (i_grd),
        .i_rpt      (i_rpt),
        .o_state1   (o_state1),
        .o_q        (o_q),
        .o_valid    (o_valid),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        d;
        logic        q;
        logic [55:0] s;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int          edge_n = 0;
    int          acc_edge = 0;
    int          pulses = 0;
    int          first_cyc = 0;
    logic [55:0] first_s;
    logic        q_seen[$];
    logic        done_seen;
    logic        mq;
    logic [55:0] mchl;
    int          n_cyc;
    bit          stop;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            pulses++;
            if (pulses == 1) begin
                first_cyc = edge_n - acc_edge + 1;
                first_s   = o_state1;
            end
            q_seen.push_back(o_q);
        end
        if (o_done === 1'b1) done_seen = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_valid, o_done, o_q, o_state1} !== {e.v, e.d, e.q, e.s}) begin
                errors++;
                $display("FAIL cycle %0d: got valid=%b done=%b q=%b state1=%h, expected valid=%b done=%b q=%b state1=%h",
                         edge_n, o_valid, o_done, o_q, o_state1, e.v, e.d, e.q, e.s);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [55:0] lfsr(input logic [55:0] c);
        return {c[54:0], c[55] ^ c[54] ^ c[34] ^ c[33]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic v, input logic d);
        exp_q.push_back('{v, d, mq, mchl});
    endtask

    // One cycle of an active run; act_at selects the cycle in which i_go drops or reset asserts.
    task automatic step(input logic v, input logic [55:0] key, input int act_at, input bit use_rst);
        if (stop) return;
        if (v) mq = ^(mchl & key);
        push(v, 1'b0);
        if (n_cyc == act_at) begin
            stop = 1'b1;
            i_go = 1'b0;
            if (use_rst) rst_n = 1'b0;
        end
        n_cyc++;
        tick();
    endtask

    task automatic run(input logic [55:0] seed, input logic [55:0] key, input int chx, input int grd,
                       input int rpt, input int act_at, input bit use_rst, input int hold);
        int ec, er;
        i_chl_seed = seed;
        i_key1     = key;
        i_chx      = 8'(chx);
        i_grd      = 8'(grd);
        i_rpt      = 4'(rpt);
        i_go       = 1'b1;
        push(1'b0, 1'b0);
        tick();
        acc_edge  = edge_n;
        pulses    = 0;
        done_seen = 1'b0;
        q_seen.delete();
        mchl  = (seed == '0) ? 56'd1 : seed;
        ec    = (chx == 0) ? 1 : chx;
        er    = (rpt == 0) ? 1 : rpt;
        n_cyc = 0;
        stop  = 1'b0;
        for (int c = 0; c < ec; c++) begin
            for (int g = 0; g < grd; g++) step(1'b0, key, act_at, use_rst);
            for (int r = 0; r < er; r++) begin
                step(1'b1, key, act_at, use_rst);
                step(1'b0, key, act_at, use_rst);
            end
            if (!stop) mchl = lfsr(mchl);
        end
        if (stop) begin
            if (use_rst) begin
                mq   = 1'b0;
                mchl = '0;
                push(1'b0, 1'b0);
                rst_n = 1'b1;
                tick();
            end
            repeat (2) begin
                push(1'b0, 1'b0);
                tick();
            end
        end else begin
            for (int h = 0; h < hold; h++) begin
                push(1'b0, 1'b1);
                tick();
            end
            push(1'b0, 1'b1);
            i_go = 1'b0;
            tick();
            push(1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [55:0] s, k;
        int chx, grd, rpt, total, act;
        bit ur;
        rst_n      = 1'b0;
        i_go       = 1'b0;
        i_chl_seed = '0;
        i_key1     = '0;
        i_chx      = '0;
        i_grd      = '0;
        i_rpt      = '0;
        mq         = 1'b0;
        mchl       = '0;
        repeat (2) @(posedge clk);
        #2;
        push(1'b0, 1'b0);
        tick();
        push(1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        push(1'b0, 1'b0);
        tick();

        run(56'h1, 56'h1, 1, 0, 1, -1, 1'b0, 2);
        chk("single_pulses", 64'(pulses), 64'd1);
        chk("single_q", 64'(q_seen[0]), 64'd1);
        chk("single_done", 64'(done_seen), 64'd1);

        run(56'h1, 56'h2, 3, 0, 1, -1, 1'b0, 0);
        chk("seq_pulses", 64'(pulses), 64'd3);
        chk("seq_q", 64'({q_seen[0], q_seen[1], q_seen[2]}), 64'b010);
        chk("seq_final_state1", 64'(o_state1), 64'h8);

        run(56'h0123_4567_89ab, 56'hff_0f0f_f0f0_3c3c, 2, 5, 3, -1, 1'b0, 1);
        chk("guard_pulses", 64'(pulses), 64'd6);
        chk("guard_first_valid_cycle", 64'(first_cyc), 64'd6);

        run(56'h0, 56'hab_cdef_1234_5678, 0, 1, 0, -1, 1'b0, 0);
        chk("zero_pulses", 64'(pulses), 64'd1);
        chk("zero_loaded_chl", 64'(first_s), 64'h1);
        chk("zero_final_state1", 64'(o_state1), 64'h2);

        run(56'h55_aaaa_5555_aaaa, 56'h12_3456_789a_bcde, 4, 0, 2, 3, 1'b0, 0);
        chk("abort_pulses", 64'(pulses), 64'd2);
        chk("abort_done_seen", 64'(done_seen), 64'd0);
        chk("abort_chl_kept", 64'(o_state1), 64'h55_aaaa_5555_aaaa);
        run(56'h55_aaaa_5555_aaaa, 56'h12_3456_789a_bcde, 1, 0, 1, -1, 1'b0, 0);
        chk("restart_first_chl", 64'(first_s), 64'h55_aaaa_5555_aaaa);

        run(56'hde_adbe_efca_fe00, 56'hff_ffff_ffff_ffff, 3, 2, 2, 2, 1'b1, 0);
        chk("reset_valid", 64'(o_valid), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_q", 64'(o_q), 64'd0);
        chk("reset_state1", 64'(o_state1), 64'd0);

        for (int i = 0; i < 40; i++) begin
            s     = 56'({$urandom(), $urandom()});
            k     = 56'({$urandom(), $urandom()});
            if ($urandom_range(0, 7) == 0) s = '0;
            chx   = $urandom_range(0, 6);
            grd   = $urandom_range(0, 4);
            rpt   = $urandom_range(0, 4);
            total = ((chx == 0) ? 1 : chx) * (grd + 2 * ((rpt == 0) ? 1 : rpt));
            act   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
            ur    = ($urandom_range(0, 1) == 1);
            run(s, k, chx, grd, rpt, act, ur, $urandom_range(0, 3));
        end

        repeat (3) begin
            push(1'b0, 1'b0);
            tick();
        end
        while (exp_q.size() > 0) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
